// File: rtl/sobel_frame_ctrl.sv
// Frame-level controller beside the Sobel datapath: tracks Y timing, swaps threshold/mode
// at frame start, flags geometry errors and emits a border mask aligned to the Sobel output.
module sobel_frame_ctrl #(
  parameter logic [11:0] H_DISP     = 12'd640,
  parameter logic [11:0] V_DISP     = 12'd480,
  parameter int          PIPE_LAT   = 4,
  parameter logic [10:0] THRESH_RST = 11'd50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Y_de,
  input  logic        Y_vsync,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [10:0] cfg_thresh,
  input  logic [1:0]  cfg_mode,
  output logic [10:0] sobel_thresh,
  output logic [1:0]  sobel_mode,
  output logic        border_mask,
  output logic [15:0] frame_cnt,
  output logic        err_h,
  output logic        err_v,
  input  logic        err_clr
);

  typedef enum logic [1:0] {S_IDLE, S_VBLANK, S_LINE, S_HBLANK} state_t;

  state_t              state, state_nxt;
  logic [11:0]         x_cnt, x_nxt, y_cnt, y_nxt;
  logic                Y_de_d, Y_vsync_d;
  logic                vs_rise, de_rise, de_fall;
  logic                frame_end, h_bad;
  logic                pending, cfg_xfer;
  logic [10:0]         shadow_thresh;
  logic [1:0]          shadow_mode;
  logic                raw_border;
  logic [PIPE_LAT-1:0] border_p;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  // Reserved mode 3 behaves as plain edge mode.
  function automatic logic [1:0] legal_mode(input logic [1:0] m);
    return (m == 2'd3) ? 2'd0 : m;
  endfunction

  assign vs_rise   = Y_vsync & ~Y_vsync_d;
  assign de_rise   = Y_de & ~Y_de_d;
  assign de_fall   = ~Y_de & Y_de_d;
  assign cfg_ready = ~pending;
  assign cfg_xfer  = cfg_valid & ~pending;

  always_comb begin
    state_nxt = state;
    x_nxt     = x_cnt;
    y_nxt     = y_cnt;
    frame_end = 1'b0;
    h_bad     = 1'b0;
    if (vs_rise) begin
      state_nxt = S_VBLANK;
      x_nxt     = '0;
      y_nxt     = '0;
      frame_end = (state != S_IDLE);
    end else begin
      case (state)
        S_VBLANK, S_HBLANK: begin
          if (de_rise) begin
            state_nxt = S_LINE;
            x_nxt     = 12'd1;
          end
        end
        S_LINE: begin
          if (de_fall) begin
            state_nxt = S_HBLANK;
            y_nxt     = sat_inc(y_cnt);
            x_nxt     = '0;
            h_bad     = (x_cnt != H_DISP);
          end else if (Y_de) begin
            x_nxt = sat_inc(x_cnt);
          end
        end
        default: ;
      endcase
    end
  end

  // x_cnt holds the count of pixels already seen on the line, i.e. the current pixel's x.
  assign raw_border = Y_de && (state != S_IDLE) &&
                      ((x_cnt == 12'd0) || (x_cnt == H_DISP - 12'd1) ||
                       (y_cnt == 12'd0) || (y_cnt == V_DISP - 12'd1));

  assign border_mask = border_p[PIPE_LAT-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      x_cnt        <= '0;
      y_cnt        <= '0;
      Y_de_d       <= 1'b0;
      Y_vsync_d    <= 1'b0;
      frame_cnt    <= '0;
      err_h        <= 1'b0;
      err_v        <= 1'b0;
      pending      <= 1'b0;
      sobel_thresh <= THRESH_RST;
      sobel_mode   <= 2'd0;
      border_p     <= '0;
    end else begin
      state     <= state_nxt;
      x_cnt     <= x_nxt;
      y_cnt     <= y_nxt;
      Y_de_d    <= Y_de;
      Y_vsync_d <= Y_vsync;
      if (frame_end) frame_cnt <= frame_cnt + 16'd1;
      if (h_bad) err_h <= 1'b1;
      else if (err_clr) err_h <= 1'b0;
      if (frame_end && (y_cnt != V_DISP)) err_v <= 1'b1;
      else if (err_clr) err_v <= 1'b0;
      // A transfer is only possible with pending low, so apply and accept never collide.
      if (vs_rise && pending) begin
        sobel_thresh <= shadow_thresh;
        sobel_mode   <= shadow_mode;
        pending      <= 1'b0;
      end
      if (cfg_xfer) pending <= 1'b1;
      for (int i = PIPE_LAT - 1; i > 0; i--) border_p[i] <= border_p[i-1];
      border_p[0] <= raw_border;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_xfer) begin
      shadow_thresh <= cfg_thresh;
      shadow_mode   <= legal_mode(cfg_mode);
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Scoreboard bench for sobel_frame_ctrl with an 8x4 frame and 4-cycle border latency.
module tb_sobel_frame_ctrl;
  localparam int H = 8;
  localparam int V = 4;
  localparam int L = 4;

  logic        clk, rst_n, Y_de, Y_vsync, cfg_valid, cfg_ready, err_clr;
  logic [10:0] cfg_thresh, sobel_thresh;
  logic [1:0]  cfg_mode, sobel_mode;
  logic        border_mask, err_h, err_v;
  logic [15:0] frame_cnt;

  int   n_chk = 0;
  int   n_err = 0;
  logic exp_q[$];
  int   exp_frames = 0;
  logic exp_errh = 1'b0;
  logic exp_errv = 1'b0;

  sobel_frame_ctrl #(
    .H_DISP(12'd8), .V_DISP(12'd4), .PIPE_LAT(L), .THRESH_RST(11'd50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Y_de(Y_de), .Y_vsync(Y_vsync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_thresh(cfg_thresh),
    .cfg_mode(cfg_mode), .sobel_thresh(sobel_thresh), .sobel_mode(sobel_mode),
    .border_mask(border_mask), .frame_cnt(frame_cnt), .err_h(err_h),
    .err_v(err_v), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic bexp(input int x, input int y);
    return (x == 0) || (x == H - 1) || (y == 0) || (y == V - 1);
  endfunction

  // One clock of stimulus; the expected raw border is queued and compared L cycles later.
  task automatic cyc(input logic de, input logic vs, input logic eb);
    logic e;
    Y_de = de;
    Y_vsync = vs;
    exp_q.push_back(eb);
    @(negedge clk);
    if (exp_q.size() > L) begin
      e = exp_q.pop_front();
      chk("border", 32'(border_mask), 32'(e));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y);
    cyc(1'b1, 1'b0, bexp(x, y));
  endtask

  task automatic line_tail(input int npix, input logic clr);
    err_clr = clr;
    cyc(1'b0, 1'b0, 1'b0);
    err_clr = 1'b0;
    if (npix != H) exp_errh = 1'b1;
    else if (clr) exp_errh = 1'b0;
    if (clr) exp_errv = 1'b0;
    chk("err_h_line", 32'(err_h), 32'(exp_errh));
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic line(input int y, input int npix, input logic clr);
    for (int x = 0; x < npix; x++) pix(x, y);
    line_tail(npix, clr);
  endtask

  task automatic frame4();
    for (int y = 0; y < V; y++) line(y, H, 1'b0);
  endtask

  task automatic vs_hi();
    cyc(1'b0, 1'b1, 1'b0);
  endtask

  task automatic vs_tail();
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_frame();
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    chk("err_h", 32'(err_h), 32'(exp_errh));
    chk("err_v", 32'(err_v), 32'(exp_errv));
  endtask

  task automatic check_cfg(input logic [10:0] th, input logic [1:0] md, input logic rdy);
    chk("sobel_thresh", 32'(sobel_thresh), 32'(th));
    chk("sobel_mode", 32'(sobel_mode), 32'(md));
    chk("cfg_ready", 32'(cfg_ready), 32'(rdy));
  endtask

  initial begin
    #300000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0; Y_de = 1'b0; Y_vsync = 1'b0; cfg_valid = 1'b0;
    cfg_thresh = '0; cfg_mode = '0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_frame();
    check_cfg(11'd50, 2'd0, 1'b1);
    chk("border_rst", 32'(border_mask), 32'd0);
    rst_n = 1'b1;

    // Clean frame: first vsync from idle is not counted
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    vs_hi();
    check_frame();
    vs_tail();
    frame4();
    vs_hi();
    exp_frames = 1;
    check_frame();
    check_cfg(11'd50, 2'd0, 1'b1);
    vs_tail();

    // Config accepted mid-line, second request refused, applied at next vsync
    for (int x = 0; x < H; x++) begin
      cfg_valid  = (x == 2) || (x == 4);
      cfg_thresh = (x == 2) ? 11'd100 : 11'd200;
      cfg_mode   = (x == 2) ? 2'd1 : 2'd2;
      pix(x, 0);
      if (x == 2) chk("cfg_ready_busy", 32'(cfg_ready), 32'd0);
    end
    cfg_valid = 1'b0;
    line_tail(H, 1'b0);
    for (int y = 1; y < V; y++) line(y, H, 1'b0);
    check_cfg(11'd50, 2'd0, 1'b0);
    vs_hi();
    exp_frames = 2;
    check_cfg(11'd100, 2'd1, 1'b1);
    check_frame();
    vs_tail();

    // Short line, then a short frame, then clears
    line(0, H, 1'b0);
    line(1, 7, 1'b0);
    line(2, H, 1'b0);
    line(3, H, 1'b0);
    vs_hi();
    exp_frames = 3;
    check_frame();
    vs_tail();
    for (int y = 0; y < 3; y++) line(y, H, 1'b0);
    vs_hi();
    exp_frames = 4;
    exp_errv = 1'b1;
    check_frame();
    vs_tail();
    err_clr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    err_clr = 1'b0;
    exp_errh = 1'b0;
    exp_errv = 1'b0;
    check_frame();
    line(0, 6, 1'b1);
    for (int y = 1; y < V; y++) line(y, H, 1'b0);

    // Config transfer coincident with vsync waits for the following vsync
    cfg_valid = 1'b1; cfg_thresh = 11'd300; cfg_mode = 2'd2;
    vs_hi();
    cfg_valid = 1'b0;
    exp_frames = 5;
    check_frame();
    check_cfg(11'd100, 2'd1, 1'b0);
    vs_tail();
    frame4();
    check_cfg(11'd100, 2'd1, 1'b0);
    vs_hi();
    exp_frames = 6;
    check_cfg(11'd300, 2'd2, 1'b1);
    vs_tail();

    // Vsync while de is high ends the frame at once
    line(0, H, 1'b0);
    line(1, H, 1'b0);
    for (int x = 0; x < 4; x++) pix(x, 2);
    cyc(1'b1, 1'b1, bexp(4, 2));
    exp_frames = 7;
    exp_errv = 1'b1;
    check_frame();
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    err_clr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    err_clr = 1'b0;
    exp_errh = 1'b0;
    exp_errv = 1'b0;
    check_frame();
    frame4();
    vs_hi();
    exp_frames = 8;
    check_frame();
    vs_tail();

    // One-cycle reset mid-line
    pix(0, 0);
    pix(1, 0);
    pix(2, 0);
    rst_n = 1'b0;
    Y_de = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    exp_frames = 0;
    check_frame();
    check_cfg(11'd50, 2'd0, 1'b1);
    chk("border_after_rst", 32'(border_mask), 32'd0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < H; i++) cyc(1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    vs_hi();
    check_frame();
    vs_tail();
    frame4();
    vs_hi();
    exp_frames = 1;
    check_frame();
    vs_tail();
    repeat (L) cyc(1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
